// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M execute unit (mul/mulh/mulhsu/mulhu/div/divu/rem/remu).
// One operation in flight; fixed 34-cycle latency from the accepting edge to done.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             request strobe for a new operation
//   op_onehot[7:0]    decoder M bits: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
//   rs1_val, rs2_val  operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   rd_in             destination register index
//   kill              pipeline flush; aborts the in-flight operation
//   busy              high in PREP, CALC, FIX
//   done              one-cycle pulse; result and rd_out valid
//   result, rd_out    registered result and destination; held until the next done
//
// Handshake: a request is taken on a rising edge where start=1, kill=0, op_onehot is
// exactly one-hot and the unit is in IDLE or DONE. There is no backpressure on the
// result side: done is a single-cycle pulse and the consumer must take it then.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      op_onehot,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] acc;
  logic [4:0]        cnt;

  logic op_valid, accept;
  assign op_valid = (op_onehot != 8'd0) && ((op_onehot & (op_onehot - 8'd1)) == 8'd0);
  assign accept   = start && !kill && op_valid && (state == S_IDLE || state == S_DONE);

  assign busy = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  // Operand signedness from the latched op.
  logic is_mul, is_div, a_signed, b_signed;
  assign is_mul   = |op_q[3:0];
  assign is_div   = op_q[4] | op_q[6];
  assign a_signed = op_q[1] | op_q[2] | op_q[4] | op_q[6];
  assign b_signed = op_q[1] | op_q[4] | op_q[6];

  logic            a_is_neg, b_is_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  assign a_is_neg = a_signed & a_q[XLEN-1];
  assign b_is_neg = b_signed & b_q[XLEN-1];
  assign a_abs    = a_is_neg ? -a_q : a_q;
  assign b_abs    = b_is_neg ? -b_q : b_q;

  // Multiply step: add multiplicand into the high half when the current multiplier
  // bit is set, then shift the whole 64-bit accumulator right by one.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (b_mag[0] ? a_mag : '0)};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: acc high = partial remainder, acc low = quotient bits.
  // The shifted remainder can need XLEN+1 bits; when it is >= divisor the true
  // difference is below the divisor, so the low XLEN bits of the subtraction suffice.
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  assign div_shift = {acc[2*XLEN-1:XLEN], a_mag[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_mag};
  assign div_sub   = div_shift[XLEN-1:0] - b_mag;
  assign div_next  = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};

  // Sign fix-up and output selection.
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic [2*XLEN-1:0] prod;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   quo, rem, q_fix, r_fix, fix_val;
  assign prod     = (a_neg ^ b_neg) ? -acc : acc;
  assign quo      = acc[XLEN-1:0];
  assign rem      = acc[2*XLEN-1:XLEN];
  assign div_zero = (b_q == '0);
  assign div_ovf  = is_div && (a_q == INT_MIN) && (b_q == '1);
  assign q_fix    = div_zero ? '1 : div_ovf ? INT_MIN : ((a_neg ^ b_neg) ? -quo : quo);
  assign r_fix    = div_zero ? a_q : div_ovf ? '0 : (a_neg ? -rem : rem);

  always_comb begin
    fix_val = '0;
    if (op_q[0])                fix_val = prod[XLEN-1:0];
    else if (|op_q[3:1])        fix_val = prod[2*XLEN-1:XLEN];
    else if (op_q[4] | op_q[5]) fix_val = q_fix;
    else if (op_q[6] | op_q[7]) fix_val = r_fix;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_PREP;
      S_PREP: state_nxt = kill ? S_IDLE : S_CALC;
      S_CALC: begin
        if (kill)              state_nxt = S_IDLE;
        else if (cnt == 5'd31) state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = kill ? S_IDLE : S_DONE;
      S_DONE: state_nxt = accept ? S_PREP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      if (accept) begin
        op_q <= op_onehot;
        a_q  <= rs1_val;
        b_q  <= rs2_val;
        rd_q <= rd_in;
      end
      case (state)
        S_PREP: begin
          a_mag <= a_abs;
          b_mag <= b_abs;
          a_neg <= a_is_neg;
          b_neg <= b_is_neg;
          acc   <= '0;
          cnt   <= '0;
        end
        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (is_mul) begin
            acc   <= mul_next;
            b_mag <= b_mag >> 1;
          end else begin
            acc   <= div_next;
            a_mag <= a_mag << 1;
          end
        end
        S_FIX: begin
          if (!kill) begin
            result <= fix_val;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// Expected {rd, result} pairs are pushed to exp_q when an operation is launched and
// popped when done is observed. Inputs change and outputs are sampled on negedges.
module tb_muldiv_unit;

  localparam int LAT     = 34;
  localparam int TIMEOUT = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [7:0]  op_onehot = 8'd0;
  logic [31:0] rs1_val = 32'd0;
  logic [31:0] rs2_val = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_onehot(op_onehot),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .kill(kill),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    longint p;
    logic [63:0] up;
    sa = a;
    sb = b;
    model = 32'd0;
    case (op)
      8'h01: begin up = {32'd0, a} * {32'd0, b}; model = up[31:0]; end
      8'h02: begin p = longint'(sa) * longint'(sb); model = p[63:32]; end
      8'h04: begin p = longint'(sa) * longint'({32'd0, b}); model = p[63:32]; end
      8'h08: begin up = {32'd0, a} * {32'd0, b}; model = up[63:32]; end
      8'h10: begin
        if (b == 32'd0) model = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
        else model = sa / sb;
      end
      8'h20: model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      8'h40: begin
        if (b == 32'd0) model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'd0;
        else model = sa % sb;
      end
      8'h80: model = (b == 32'd0) ? a : a % b;
      default: model = 32'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Call on a negedge; returns 1 ns after the accepting edge.
  task automatic launch(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] e);
    start     = 1'b1;
    op_onehot = op;
    rs1_val   = a;
    rs2_val   = b;
    rd_in     = rd;
    exp_q.push_back({rd, e});
    @(posedge clk);
    #1;
    start     = 1'b0;
    op_onehot = 8'd0;
  endtask

  // Counts cycles after the accepting edge until done is seen (lat = edge index of the
  // done cycle), recording whether busy stayed high until then.
  task automatic run_to_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      lat++;
      if (lat > TIMEOUT) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
    tests++; if (rd_out !== 5'd0)  begin fails++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
  endtask

  task automatic test_mul();
    int lat;
    bit bok;
    logic [36:0] e;
    @(negedge clk);
    launch(8'h01, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB);
    run_to_done(lat, bok);
    e = exp_q.pop_front();
    tests++; if (lat != LAT) begin fails++; $display("FAIL mul_latency: got %0d want %0d", lat, LAT); end
    tests++; if (!bok || busy !== 1'b0) begin fails++; $display("FAIL mul_busy: held=%0d at_done=%b want 1/0", bok, busy); end
    tests++; if (result !== e[31:0]) begin fails++; $display("FAIL mul_result: got %h want %h", result, e[31:0]); end
    tests++; if (rd_out !== e[36:32]) begin fails++; $display("FAIL mul_rd: got %0d want %0d", rd_out, e[36:32]); end
    last_res = e[31:0]; last_rd = e[36:32];
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mul_done_pulse: done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_arith_table();
    vec_t tbl [12];
    int lat;
    bit bok;
    logic [36:0] e;
    tbl[0]  = '{8'h02, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[1]  = '{8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2]  = '{8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3]  = '{8'h10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    tbl[4]  = '{8'h40, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    tbl[5]  = '{8'h20, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC};
    tbl[6]  = '{8'h80, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001};
    tbl[7]  = '{8'h10, 32'd5,         32'd0,         32'hFFFF_FFFF};
    tbl[8]  = '{8'h40, 32'd5,         32'd0,         32'd5};
    tbl[9]  = '{8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[10] = '{8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    tbl[11] = '{8'h40, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      launch(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].e);
      run_to_done(lat, bok);
      e = exp_q.pop_front();
      tests++; if (lat != LAT) begin fails++; $display("FAIL table%0d_latency: got %0d want %0d", i, lat, LAT); end
      tests++; if (!bok || busy !== 1'b0) begin fails++; $display("FAIL table%0d_busy: held=%0d at_done=%b want 1/0", i, bok, busy); end
      tests++; if (result !== e[31:0]) begin fails++; $display("FAIL table%0d_result: op=%h got %h want %h", i, tbl[i].op, result, e[31:0]); end
      tests++; if (rd_out !== e[36:32]) begin fails++; $display("FAIL table%0d_rd: got %0d want %0d", i, rd_out, e[36:32]); end
      last_res = e[31:0]; last_rd = e[36:32];
    end
  endtask

  task automatic test_random();
    int lat;
    bit bok;
    logic [36:0] e;
    logic [7:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 8'(1 << $urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 5 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) a = 32'($urandom_range(0, 5000));
      @(negedge clk);
      launch(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b));
      run_to_done(lat, bok);
      e = exp_q.pop_front();
      tests++; if (lat != LAT) begin fails++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, LAT); end
      tests++; if (result !== e[31:0] || rd_out !== e[36:32]) begin
        fails++;
        $display("FAIL rand%0d_result: op=%h a=%h b=%h got %h/%0d want %h/%0d", i, op, a, b, result, rd_out, e[31:0], e[36:32]);
      end
      last_res = e[31:0]; last_rd = e[36:32];
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit bok;
    int extra;
    logic [36:0] e;
    @(negedge clk);
    launch(8'h01, 32'd3, 32'd5, 5'd3, 32'd15);
    lat = 0;
    bok = 1'b1;
    forever begin
      @(negedge clk);
      if (lat == 6) begin start = 1'b0; op_onehot = 8'd0; end
      if (done === 1'b1) break;
      if (busy !== 1'b1) bok = 1'b0;
      if (lat == 5) begin
        start = 1'b1; op_onehot = 8'h10; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd9;
      end
      lat++;
      if (lat > TIMEOUT) break;
    end
    e = exp_q.pop_front();
    tests++; if (lat != LAT || !bok) begin fails++; $display("FAIL busy_start_latency: got %0d held=%0d want %0d/1", lat, bok, LAT); end
    tests++; if (result !== e[31:0] || rd_out !== e[36:32]) begin
      fails++; $display("FAIL busy_start_result: got %h/%0d want %h/%0d", result, rd_out, e[31:0], e[36:32]);
    end
    last_res = e[31:0]; last_rd = e[36:32];
    extra = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) extra++; end
    tests++; if (extra != 0) begin fails++; $display("FAIL busy_start_ignored: activity cycles %0d want 0", extra); end
  endtask

  task automatic test_bad_start();
    int seen;
    logic [7:0] ops [3];
    logic       kills [3];
    ops[0] = 8'h30; kills[0] = 1'b0;
    ops[1] = 8'h00; kills[1] = 1'b0;
    ops[2] = 8'h01; kills[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; op_onehot = ops[i]; kill = kills[i];
      rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd30;
      @(posedge clk);
      #1;
      start = 1'b0; op_onehot = 8'd0; kill = 1'b0;
      seen = 0;
      repeat (40) begin @(negedge clk); if (busy === 1'b1 || done === 1'b1) seen++; end
      tests++; if (seen != 0) begin fails++; $display("FAIL bad_start%0d: op=%h kill=%b activity %0d want 0", i, ops[i], kills[i], seen); end
      tests++; if (result !== last_res || rd_out !== last_rd) begin
        fails++; $display("FAIL bad_start%0d_hold: got %h/%0d want %h/%0d", i, result, rd_out, last_res, last_rd);
      end
    end
  endtask

  task automatic test_kill();
    int seen;
    @(negedge clk);
    launch(8'h10, 32'd1000, 32'd7, 5'd12, 32'd142);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL kill_busy: got %b want 0", busy); end
    seen = 0;
    repeat (45) begin @(negedge clk); if (done === 1'b1) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL kill_no_done: done cycles %0d want 0", seen); end
    tests++; if (result !== last_res || rd_out !== last_rd) begin
      fails++; $display("FAIL kill_hold: got %h/%0d want %h/%0d", result, rd_out, last_res, last_rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok;
    logic [36:0] e;
    @(negedge clk);
    launch(8'h20, 32'd100, 32'd7, 5'd5, 32'd14);
    run_to_done(lat, bok);
    e = exp_q.pop_front();
    tests++; if (lat != LAT || result !== e[31:0] || rd_out !== e[36:32]) begin
      fails++; $display("FAIL b2b_first: lat %0d got %h/%0d want %0d %h/%0d", lat, result, rd_out, LAT, e[31:0], e[36:32]);
    end
    // Still in the DONE cycle: request the next op now.
    launch(8'h80, 32'd100, 32'd7, 5'd6, 32'd2);
    run_to_done(lat, bok);
    e = exp_q.pop_front();
    tests++; if (lat != LAT || !bok) begin fails++; $display("FAIL b2b_latency: got %0d held=%0d want %0d/1", lat, bok, LAT); end
    tests++; if (result !== e[31:0] || rd_out !== e[36:32]) begin
      fails++; $display("FAIL b2b_second: got %h/%0d want %h/%0d", result, rd_out, e[31:0], e[36:32]);
    end
    last_res = e[31:0]; last_rd = e[36:32];
  endtask

  task automatic test_async_reset();
    int lat;
    bit bok;
    logic [36:0] e;
    @(negedge clk);
    launch(8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE);
    repeat (12) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
      fails++; $display("FAIL async_reset: busy=%b done=%b result=%h rd=%0d want all 0", busy, done, result, rd_out);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(8'h01, 32'h0001_2345, 32'h0000_0100, 5'd21, model(8'h01, 32'h0001_2345, 32'h0000_0100));
    run_to_done(lat, bok);
    e = exp_q.pop_front();
    tests++; if (lat != LAT || result !== e[31:0] || rd_out !== e[36:32]) begin
      fails++; $display("FAIL post_reset_op: lat %0d got %h/%0d want %0d %h/%0d", lat, result, rd_out, LAT, e[31:0], e[36:32]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mul();
    test_arith_table();
    test_random();
    test_start_while_busy();
    test_bad_start();
    test_kill();
    test_back_to_back();
    test_async_reset();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
